// File: rtl/hilo_unit_if.sv
// Bus bundle between the CPU control/mult-div datapath and the HI/LO register unit.
interface hilo_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             op_sel;
   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] mul_lo;
   logic [WIDTH-1:0] div_hi;
   logic [WIDTH-1:0] div_lo;
   logic             mthi_en;
   logic             mtlo_en;
   logic [WIDTH-1:0] wdata;
   logic             rd_sel;
   logic [WIDTH-1:0] rdata;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             wr_conflict;

   modport slave (
      input  start, op_sel, mul_hi, mul_lo, div_hi, div_lo,
      input  mthi_en, mtlo_en, wdata, rd_sel,
      output rdata, hi, lo, busy, done, wr_conflict
   );

   modport master (
      output start, op_sel, mul_hi, mul_lo, div_hi, div_lo,
      output mthi_en, mtlo_en, wdata, rd_sel,
      input  rdata, hi, lo, busy, done, wr_conflict
   );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register pair: sequences one fixed-latency mult/div op per start, captures the
// result, and serves mthi/mtlo writes and mfhi/mflo reads.
module hilo_unit #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MUL_LATENCY = 2,
   parameter int unsigned DIV_LATENCY = 34
) (
   input  logic       clock,
   input  logic       reset,
   hilo_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [5:0] MUL_CNT = 6'(MUL_LATENCY - 1);
   localparam logic [5:0] DIV_CNT = 6'(DIV_LATENCY - 1);

   state_t           state_q, state_d;
   logic [5:0]       cnt_q, cnt_d;
   logic             op_q, op_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             wr_conflict_q, wr_conflict_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         op_q          <= 1'b0;
         hi_q          <= '0;
         lo_q          <= '0;
         wr_conflict_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         op_q          <= op_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         wr_conflict_q <= wr_conflict_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      hi_d          = hi_q;
      lo_d          = lo_q;
      wr_conflict_d = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.mthi_en) hi_d = bus.wdata;
            if (bus.mtlo_en) lo_d = bus.wdata;
            if (bus.start) begin
               state_d = WAIT;
               op_d    = bus.op_sel;
               cnt_d   = bus.op_sel ? DIV_CNT : MUL_CNT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            // Register writes are dropped while an op is in flight; flag it next cycle.
            wr_conflict_d = bus.mthi_en | bus.mtlo_en;
            if (cnt_q != 6'd0) begin
               cnt_d = cnt_q - 6'd1;
            end else begin
               hi_d    = op_q ? bus.div_hi : bus.mul_hi;
               lo_d    = op_q ? bus.div_lo : bus.mul_lo;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.rdata       = bus.rd_sel ? lo_q : hi_q;
   assign bus.busy        = (state_q == WAIT);
   assign bus.done        = (state_q == DONE);
   assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with an edge-indexed reference model checked every cycle.
module tb_hilo_unit;

   localparam int W   = 32;
   localparam int MUL = 2;
   localparam int DIV = 34;

   logic clock;
   logic reset;

   hilo_unit_if #(.WIDTH(W)) bus ();

   hilo_unit #(
      .WIDTH      (W),
      .MUL_LATENCY(MUL),
      .DIV_LATENCY(DIV)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: an op accepted at edge n completes at edge n+LAT; done is high
   // in the cycle following the completion edge.
   int           edge_n     = 0;
   bit           m_valid    = 0;
   bit           m_pending  = 0;
   int           m_cap_edge = 0;
   int           m_last_cap = -10;
   bit           m_op       = 0;
   bit           m_conf     = 0;
   logic [W-1:0] m_hi       = '0;
   logic [W-1:0] m_lo       = '0;

   always @(posedge clock) begin
      edge_n++;
      if (reset) begin
         m_valid    = 1;
         m_pending  = 0;
         m_last_cap = -10;
         m_conf     = 0;
         m_op       = 0;
         m_hi       = '0;
         m_lo       = '0;
      end else begin
         m_conf = m_pending && (bus.mthi_en || bus.mtlo_en);
         if (!m_pending) begin
            if (bus.mthi_en) m_hi = bus.wdata;
            if (bus.mtlo_en) m_lo = bus.wdata;
            if (bus.start) begin
               m_pending  = 1;
               m_op       = bus.op_sel;
               m_cap_edge = edge_n + (bus.op_sel ? DIV : MUL);
            end
         end else if (edge_n == m_cap_edge) begin
            m_hi       = m_op ? bus.div_hi : bus.mul_hi;
            m_lo       = m_op ? bus.div_lo : bus.mul_lo;
            m_pending  = 0;
            m_last_cap = edge_n;
         end
      end
      #1;
      if (m_valid) begin
         chk("m_hi",    bus.hi, m_hi);
         chk("m_lo",    bus.lo, m_lo);
         chk("m_rdata", bus.rdata, bus.rd_sel ? m_lo : m_hi);
         chk("m_busy",  W'(bus.busy), W'(m_pending));
         chk("m_done",  W'(bus.done), W'(m_last_cap == edge_n));
         chk("m_wrc",   W'(bus.wr_conflict), W'(m_conf));
      end
   end

   task automatic cyc();
      @(negedge clock);
   endtask

   int nb;
   int dc;
   bit seen;

   initial begin
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.op_sel  = 1'b0;
      bus.mul_hi  = '0;
      bus.mul_lo  = '0;
      bus.div_hi  = '0;
      bus.div_lo  = '0;
      bus.mthi_en = 1'b0;
      bus.mtlo_en = 1'b0;
      bus.wdata   = '0;
      bus.rd_sel  = 1'b0;

      // T1 reset
      cyc(); cyc();
      chk("t1_hi", bus.hi, '0);
      chk("t1_lo", bus.lo, '0);
      chk("t1_busy", W'(bus.busy), '0);
      chk("t1_done", W'(bus.done), '0);
      chk("t1_wrc", W'(bus.wr_conflict), '0);
      chk("t1_rdata", bus.rdata, '0);
      reset = 1'b0;
      cyc();

      // T2 multiply
      bus.mul_hi = 32'h0000_0001; bus.mul_lo = 32'hFFFF_FFFE;
      bus.start = 1'b1; bus.op_sel = 1'b0;
      cyc(); bus.start = 1'b0;
      chk("t2_busy1", W'(bus.busy), 1);
      cyc();
      chk("t2_busy2", W'(bus.busy), 1);
      chk("t2_hold", bus.hi, '0);
      cyc();
      chk("t2_busy3", W'(bus.busy), 0);
      chk("t2_done", W'(bus.done), 1);
      chk("t2_hi", bus.hi, 32'h0000_0001);
      chk("t2_lo", bus.lo, 32'hFFFF_FFFE);
      cyc();
      chk("t2_done_end", W'(bus.done), 0);

      // T3 divide, multiplier source wiggles during the wait
      bus.div_hi = 32'd3; bus.div_lo = 32'd7;
      bus.start = 1'b1; bus.op_sel = 1'b1;
      cyc(); bus.start = 1'b0; bus.op_sel = 1'b0;
      nb = 0;
      while (bus.busy && nb < 40) begin
         nb++;
         bus.mul_hi = $urandom; bus.mul_lo = $urandom;
         cyc();
      end
      chk("t3_busy_len", W'(nb), 34);
      chk("t3_done", W'(bus.done), 1);
      chk("t3_hi", bus.hi, 32'd3);
      chk("t3_lo", bus.lo, 32'd7);
      cyc();

      // T4 dropped write in WAIT, then accepted writes in IDLE
      bus.mul_hi = 32'h0000_000A; bus.mul_lo = 32'h0000_000B;
      bus.start = 1'b1;
      cyc(); bus.start = 1'b0;
      bus.mthi_en = 1'b1; bus.wdata = 32'hDEAD_BEEF;
      cyc(); bus.mthi_en = 1'b0;
      chk("t4_wrc", W'(bus.wr_conflict), 1);
      chk("t4_hi_kept", bus.hi, 32'd3);
      cyc();
      chk("t4_wrc_end", W'(bus.wr_conflict), 0);
      chk("t4_hi_cap", bus.hi, 32'h0000_000A);
      cyc();
      bus.mthi_en = 1'b1; bus.wdata = 32'hDEAD_BEEF; bus.rd_sel = 1'b0;
      cyc(); bus.mthi_en = 1'b0;
      chk("t4_hi_wr", bus.hi, 32'hDEAD_BEEF);
      chk("t4_rdata_hi", bus.rdata, 32'hDEAD_BEEF);
      chk("t4_wrc_idle", W'(bus.wr_conflict), 0);
      bus.mtlo_en = 1'b1; bus.wdata = 32'h1234_5678;
      cyc(); bus.mtlo_en = 1'b0; bus.rd_sel = 1'b1;
      #1;
      chk("t4_rdata_lo", bus.rdata, 32'h1234_5678);
      cyc(); bus.rd_sel = 1'b0;

      // T5 reset aborts an op in flight
      bus.mul_hi = 32'd5; bus.mul_lo = 32'd6;
      bus.start = 1'b1;
      cyc(); bus.start = 1'b0; reset = 1'b1;
      cyc(); reset = 1'b0;
      chk("t5_hi", bus.hi, '0);
      chk("t5_lo", bus.lo, '0);
      chk("t5_busy", W'(bus.busy), 0);
      cyc();
      chk("t5_no_done", W'(bus.done), 0);
      bus.start = 1'b1;
      cyc(); bus.start = 1'b0;
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         cyc();
         seen = bus.done;
      end
      chk("t5_fresh_done", W'(seen), 1);
      chk("t5_fresh_hi", bus.hi, 32'd5);
      chk("t5_fresh_lo", bus.lo, 32'd6);
      cyc();

      // T6 back-to-back ops with start held through DONE
      bus.mul_hi = 32'd1; bus.mul_lo = 32'd2;
      bus.start = 1'b1; bus.op_sel = 1'b0;
      dc = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (dc == 1 && bus.busy) bus.start = 1'b0;
         if (bus.done) begin
            dc++;
            if (dc == 1) begin
               bus.mul_hi = 32'd3; bus.mul_lo = 32'd4;
            end
         end
      end
      bus.start = 1'b0;
      chk("t6_done_cnt", W'(dc), 2);
      chk("t6_hi", bus.hi, 32'd3);
      chk("t6_lo", bus.lo, 32'd4);
      cyc(); cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
